// File: rtl/rv32_pipeline_pkg.sv
// rtl/rv32_pipeline_pkg.sv - shared RV32 pipeline types and constants used by the fetch stage
package rv32_pipeline_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_WIDTH    = 32;
    localparam logic [PC_WIDTH-1:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   filled;
    } fetch_entry_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_pkt_t;

    // Sequential next fetch address; wraps naturally at the top of the address space.
    function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_ring_buf.sv
// rtl/fetch_ring_buf.sv - allocate-at-request ring buffer holding fetched {pc, instr} entries
module fetch_ring_buf
    import rv32_pipeline_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_alloc,
    input  logic [PC_WIDTH-1:0]    i_alloc_pc,
    input  logic                   i_fill,
    input  logic [INSTR_WIDTH-1:0] i_fill_instr,
    input  logic                   i_pop,
    output logic [CW-1:0]          o_count,
    output logic [CW-1:0]          o_unfilled,
    output logic                   o_head_filled,
    output fetch_pkt_t             o_head_pkt
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_alloc_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [PW-1:0] r_head_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_unfilled;
    fetch_pkt_t    r_last_pkt;

    logic          w_head_filled;

    assign w_head_filled = r_mem[r_head_ptr].filled;

    // Entry storage and pointers; a flush drops every entry but keeps payload bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_unfilled  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].filled <= 1'b0;
            end
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_unfilled  <= '0;
        end else begin
            // Pop, alloc and fill always target distinct slots, so order here is immaterial.
            if (i_pop) begin
                r_mem[r_head_ptr].filled <= 1'b0;
                r_head_ptr <= r_head_ptr + PW'(1);
            end
            if (i_alloc) begin
                r_mem[r_alloc_ptr].pc     <= i_alloc_pc;
                r_mem[r_alloc_ptr].filled <= 1'b0;
                r_alloc_ptr <= r_alloc_ptr + PW'(1);
            end
            if (i_fill) begin
                r_mem[r_fill_ptr].instr  <= i_fill_instr;
                r_mem[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr <= r_fill_ptr + PW'(1);
            end
            r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
            r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
        end
    end

    // Remember the last presented payload so the decode-side fields hold while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pkt <= '0;
        end else if (w_head_filled) begin
            r_last_pkt <= '{pc: r_mem[r_head_ptr].pc, instr: r_mem[r_head_ptr].instr};
        end
    end

    assign o_count       = r_count;
    assign o_unfilled    = r_unfilled;
    assign o_head_filled = w_head_filled;
    assign o_head_pkt    = w_head_filled ?
                           '{pc: r_mem[r_head_ptr].pc, instr: r_mem[r_head_ptr].instr} :
                           r_last_pkt;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - RV32 fetch stage: PC, issue, drop accounting; optional FETCH_MISALIGN_CHECK_EN
module instruction_fetch_stage
    import rv32_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FETCH_BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INSTR_WIDTH-1:0] if_instruction,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   fetch_misaligned
);

    localparam int CW = $clog2(FETCH_BUF_DEPTH) + 1;

    logic [PC_WIDTH-1:0] r_pc;
    logic [CW-1:0]       r_drop_cnt;

    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_unfilled;
    logic                w_head_filled;
    fetch_pkt_t          w_head_pkt;
    logic [CW:0]         w_occupancy;
    logic                w_fetch_blocked;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_req_fire;
    logic                w_fill;
    logic                w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misaligned;

    // Sticky misalignment flag: set by an unaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            r_misaligned <= |redirect_pc[1:0];
        end
    end

    assign w_fetch_blocked  = r_misaligned;
    assign w_target         = redirect_pc;
    assign fetch_misaligned = r_misaligned;
`else
    assign w_fetch_blocked  = 1'b0;
    assign w_target         = redirect_pc & ~32'h3;
    assign fetch_misaligned = 1'b0;
`endif

    // Dropped in-flight responses still occupy memory-side credit, so they count against depth.
    assign w_occupancy    = {1'b0, w_count} + {1'b0, r_drop_cnt};
    assign imem_req_valid = rst_n && !redirect_valid && !w_fetch_blocked &&
                            (w_occupancy < (CW+1)'(FETCH_BUF_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_fill         = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign if_valid       = w_head_filled && !redirect_valid;
    assign w_pop          = if_valid && if_ready;
    assign if_pc          = w_head_pkt.pc;
    assign if_instruction = w_head_pkt.instr;

    // Program counter: redirect wins, otherwise advance on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_target;
        end else if (w_req_fire) begin
            r_pc <= next_pc(r_pc);
        end
    end

    // Drop credits: every outstanding request orphaned by a redirect must be discarded on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_drop_cnt <= r_drop_cnt + w_unfilled - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    fetch_ring_buf #(
        .DEPTH (FETCH_BUF_DEPTH)
    ) u_ring_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (redirect_valid),
        .i_alloc       (w_req_fire),
        .i_alloc_pc    (r_pc),
        .i_fill        (w_fill),
        .i_fill_instr  (imem_rsp_data),
        .i_pop         (w_pop),
        .o_count       (w_count),
        .o_unfilled    (w_unfilled),
        .o_head_filled (w_head_filled),
        .o_head_pkt    (w_head_pkt)
    );

endmodule
